spiflash_sequencer: RTL
=======================

Name: spiflash_sequencer

Overview:
- Wishbone-slave command engine that programs and erases SPI flash through the flash controller's control port (address bit 22).
- Issues byte-level control-port writes: WREN, then PAGE PROGRAM (4 bytes) or 4KB SECTOR ERASE, then polls RDSR until WIP clears.
- Sits between the CPU bus and the flash controller's control port, so software never hand-sequences CS_n and bytes.

Parameters:
- LGPOLL, 24, width of the status-poll counter; poll limit is 2^LGPOLL-1 polls.

Ports:
- i_clk  in  1  system clock
- i_reset_n  in  1  asynchronous active-low reset
- i_wb_cyc, i_wb_stb, i_wb_we  in  1  slave bus strobes
- i_wb_addr  in  2  register select: 0 CTRL, 1 ADDR, 2 DATA, 3 reserved
- i_wb_data  in  32  slave write data
- o_wb_stall  out  1  tied 0
- o_wb_ack  out  1  slave ack
- o_wb_data  out  32  slave read data
- o_fl_cyc, o_fl_stb, o_fl_we  out  1  master strobes to flash control port; o_fl_we always 1
- o_fl_addr  out  23  constant 23'h400000
- o_fl_data  out  32  {23'h0, cs_n, byte}
- i_fl_stall, i_fl_ack  in  1  master handshake
- i_fl_data  in  32  control-port readback; [7:0] is the byte shifted in

Behaviour:
- Reset: all outputs 0 except o_fl_addr constant; busy=0, err=0, state IDLE.
- Slave side:
  - Every stb acked next cycle.
  - CTRL write [1:0]: 01 = program, 10 = erase, 00/11 = no-op.
  - ADDR [23:0] and DATA [31:0] are plain registers.
  - CTRL read: {busy, err, 26'h0, state[3:0]}. ADDR/DATA read back their value; addr 3 reads 0.
  - Any write while busy is ignored and sets err. A CTRL start clears err.
- Master transfer, one byte:
  - Raise cyc+stb; hold stb until !i_fl_stall.
  - Drop stb; keep cyc until i_fl_ack; drop cyc the cycle after ack.
  - One outstanding transfer; minimum 1 idle cycle between transfers.
  - Release transfer = cs_n=1, byte 8'h00.
- States:
  - IDLE -> on start: REL0 (release CS).
  - REL0 -> WEN (06) -> WREL -> OP (02 prog / 20 erase).
  - OP -> ADR: 3 transfers, ADDR[23:16], [15:8], [7:0]; erase sends [11:0] as 0.
  - ADR -> DAT for program: 4 transfers, DATA[31:24] first. ADR -> OREL directly for erase.
  - DAT -> OREL -> RDSR (05) -> STAT: dummy 00.
  - STAT: on ack, if i_fl_data[0]=1 repeat STAT, else SREL -> IDLE with busy=0.
- Busy is set the cycle after the start write and clears the cycle SREL's ack arrives.
- Bus abort (i_wb_cyc low) on the slave side does not affect a running sequence.
- Flash-side ack without an outstanding stb is ignored.
- Reset mid-sequence: master strobes drop immediately. The flash may be left with CS low; the next start's REL0 recovers it.

Optional Feature:
- Macro SPIFLASH_POLL_TIMEOUT_EN.
- Defined:
  - STAT iterations are counted with an LGPOLL-bit counter.
  - When the count reaches 2^LGPOLL-1 with WIP still 1: set err, go to SREL, then IDLE.
- Undefined: polling is unbounded and no counter is built.

Decomposition:
- Package spiflash_pkg holds:
  - state enum
  - opcodes: WREN 8'h06, PP 8'h02, SE 8'h20, RDSR 8'h05
  - register offsets
  - CTRL op codes
- Sub-module flctl_byte_xfer owns the single-byte master handshake: start/cs_n/byte in; done/rxbyte out.

Test Plan:
- Program: ADDR=24'h012345, DATA=32'hA1B2C3D4, CTRL=01, flash model WIP=1 for 3 polls.
  - Required bytes: REL, 06, REL, 02, 01, 23, 45, A1, B2, C3, D4, REL, 05, 00×4, REL.
  - busy drops after the last REL; err=0.
- Erase: ADDR=24'h0ABCDE, CTRL=10.
  - Required bytes: REL, 06, REL, 20, 0A, B0, 00, REL, 05, 00…, REL.
- Stall stress: i_fl_stall random 50%, ack delay 8 cycles.
  - Byte stream identical to the program case.
  - Never more than one transfer outstanding.
- Write DATA while busy: ignored, CTRL read shows err=1, the running sequence is unaffected. A new start clears err.
- Reset asserted during DAT: o_fl_cyc/stb=0 at once. After release, a new program completes correctly.
- With SPIFLASH_POLL_TIMEOUT_EN and LGPOLL=4, WIP stuck at 1: after 15 polls err=1, SREL issued, busy=0.

Source files
------------

// File: rtl/spiflash_pkg.sv
// Shared types and constants for the SPI flash command sequencer.
package spiflash_pkg;

   localparam int unsigned WB_DW  = 32;
   localparam int unsigned FL_AW  = 23;
   localparam logic [FL_AW-1:0] FL_CTRL_ADDR = 23'h400000;

   typedef enum logic [3:0] {
      S_IDLE = 4'd0,
      S_REL0 = 4'd1,
      S_WEN  = 4'd2,
      S_WREL = 4'd3,
      S_OP   = 4'd4,
      S_ADR  = 4'd5,
      S_DAT  = 4'd6,
      S_OREL = 4'd7,
      S_RDSR = 4'd8,
      S_STAT = 4'd9,
      S_SREL = 4'd10
   } state_t;

   typedef enum logic [1:0] {
      X_IDLE = 2'd0,
      X_REQ  = 2'd1,
      X_WAIT = 2'd2
   } xstate_t;

   localparam logic [7:0] OPC_WREN = 8'h06;
   localparam logic [7:0] OPC_PP   = 8'h02;
   localparam logic [7:0] OPC_SE   = 8'h20;
   localparam logic [7:0] OPC_RDSR = 8'h05;

   localparam logic [1:0] REG_CTRL = 2'd0;
   localparam logic [1:0] REG_ADDR = 2'd1;
   localparam logic [1:0] REG_DATA = 2'd2;
   localparam logic [1:0] REG_RSVD = 2'd3;

   localparam logic [1:0] CMD_PROG  = 2'b01;
   localparam logic [1:0] CMD_ERASE = 2'b10;

   // Control-port write word: chip select and one SPI byte.
   typedef struct packed {
      logic [22:0] pad;
      logic        cs_n;
      logic [7:0]  dat;
   } fl_word_t;

   function automatic fl_word_t fl_word(input logic cs_n, input logic [7:0] b);
      fl_word_t w;
      w      = '0;
      w.cs_n = cs_n;
      w.dat  = b;
      return w;
   endfunction

endpackage

// File: rtl/spiflash_sequencer_if.sv
// Bus interfaces: CPU-side slave bus and flash control-port master bus.
interface spiflash_wb_if;
   logic        cyc;
   logic        stb;
   logic        we;
   logic [1:0]  addr;
   logic [31:0] wdata;
   logic        stall;
   logic        ack;
   logic [31:0] rdata;

   modport master (output cyc, stb, we, addr, wdata, input stall, ack, rdata);
   modport slave  (input cyc, stb, we, addr, wdata, output stall, ack, rdata);
endinterface

interface spiflash_fl_if;
   logic        cyc;
   logic        stb;
   logic        we;
   logic [22:0] addr;
   logic [31:0] wdata;
   logic        stall;
   logic        ack;
   logic [31:0] rdata;

   modport master (output cyc, stb, we, addr, wdata, input stall, ack, rdata);
   modport slave  (input cyc, stb, we, addr, wdata, output stall, ack, rdata);
endinterface

// File: rtl/flctl_byte_xfer.sv
// Single-byte pipelined bus write to the flash control port; done_c_o pulses
// combinationally in the cycle the ack is presented.
module flctl_byte_xfer
   import spiflash_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        start_i,
   input  logic        cs_n_i,
   input  logic [7:0]  byte_i,
   input  logic        fl_stall_i,
   input  logic        fl_ack_i,
   input  logic [31:0] fl_rdata_i,
   output logic        fl_cyc_o,
   output logic        fl_stb_o,
   output logic [31:0] fl_data_o,
   output logic        done_c_o,
   output logic [7:0]  rxbyte_c_o
);

   xstate_t  state_q, state_d;
   logic     cyc_q, cyc_d;
   logic     stb_q, stb_d;
   fl_word_t word_q, word_d;

   logic unused_rdata;
   assign unused_rdata = ^fl_rdata_i[31:8];

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= X_IDLE;
         cyc_q   <= 1'b0;
         stb_q   <= 1'b0;
         word_q  <= '0;
      end else begin
         state_q <= state_d;
         cyc_q   <= cyc_d;
         stb_q   <= stb_d;
         word_q  <= word_d;
      end
   end

   // Acks are only honoured once the strobe has been accepted.
   always_comb begin
      state_d = state_q;
      cyc_d   = cyc_q;
      stb_d   = stb_q;
      word_d  = word_q;
      case (state_q)
         X_IDLE: if (start_i) begin
            cyc_d   = 1'b1;
            stb_d   = 1'b1;
            word_d  = fl_word(cs_n_i, byte_i);
            state_d = X_REQ;
         end
         X_REQ: if (!fl_stall_i) begin
            stb_d   = 1'b0;
            state_d = X_WAIT;
         end
         X_WAIT: if (fl_ack_i) begin
            cyc_d   = 1'b0;
            state_d = X_IDLE;
         end
         default: state_d = X_IDLE;
      endcase
   end

   assign fl_cyc_o   = cyc_q;
   assign fl_stb_o   = stb_q;
   assign fl_data_o  = word_q;
   assign done_c_o   = (state_q == X_WAIT) && fl_ack_i;
   assign rxbyte_c_o = fl_rdata_i[7:0];

endmodule

// File: rtl/spiflash_sequencer.sv
// SPI flash program/erase command engine behind a CPU slave bus.
// Optional bounded status polling: define SPIFLASH_POLL_TIMEOUT_EN.
module spiflash_sequencer
   import spiflash_pkg::*;
#(
   parameter int unsigned LGPOLL = 24
) (
   input  logic          i_clk,
   input  logic          i_reset_n,
   spiflash_wb_if.slave  wb,
   spiflash_fl_if.master fl
);

   state_t      state_q, state_d;
   logic        busy_q, busy_d;
   logic        err_q, err_d;
   logic        prog_q, prog_d;
   logic [1:0]  cnt_q, cnt_d;
   logic        pend_q, pend_d;
   logic        start_q, start_d;
   logic        cs_n_q, cs_n_d;
   logic [7:0]  tx_byte_q, tx_byte_d;
   logic [23:0] addr_q, addr_d;
   logic [31:0] data_q, data_d;
   logic        ack_q, ack_d;
   logic [31:0] rdata_q, rdata_d;

   logic        xfer_done;
   logic [7:0]  xfer_rx;
   logic [23:0] seq_addr;

`ifdef SPIFLASH_POLL_TIMEOUT_EN
   localparam logic [LGPOLL-1:0] POLL_LAST = {{(LGPOLL-1){1'b1}}, 1'b0};
   logic [LGPOLL-1:0] poll_q, poll_d;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) poll_q <= '0;
      else            poll_q <= poll_d;
   end
`else
   logic unused_lgpoll;
   assign unused_lgpoll = (LGPOLL == 0);
`endif

   logic unused_rx;
   assign unused_rx = ^xfer_rx[7:1];

   // Erase targets the enclosing 4KB sector.
   assign seq_addr = prog_q ? addr_q : {addr_q[23:12], 12'h000};

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q   <= S_IDLE;
         busy_q    <= 1'b0;
         err_q     <= 1'b0;
         prog_q    <= 1'b0;
         cnt_q     <= 2'd0;
         pend_q    <= 1'b0;
         start_q   <= 1'b0;
         cs_n_q    <= 1'b0;
         tx_byte_q <= 8'h00;
         addr_q    <= '0;
         data_q    <= '0;
         ack_q     <= 1'b0;
         rdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         busy_q    <= busy_d;
         err_q     <= err_d;
         prog_q    <= prog_d;
         cnt_q     <= cnt_d;
         pend_q    <= pend_d;
         start_q   <= start_d;
         cs_n_q    <= cs_n_d;
         tx_byte_q <= tx_byte_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         ack_q     <= ack_d;
         rdata_q   <= rdata_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      busy_d    = busy_q;
      err_d     = err_q;
      prog_d    = prog_q;
      cnt_d     = cnt_q;
      pend_d    = pend_q;
      start_d   = 1'b0;
      cs_n_d    = cs_n_q;
      tx_byte_d = tx_byte_q;
      addr_d    = addr_q;
      data_d    = data_q;
      ack_d     = wb.cyc & wb.stb;
      rdata_d   = '0;
`ifdef SPIFLASH_POLL_TIMEOUT_EN
      poll_d    = poll_q;
`endif

      if (wb.cyc && wb.stb && !wb.we) begin
         case (wb.addr)
            REG_CTRL: rdata_d = {busy_q, err_q, 26'h0, state_q};
            REG_ADDR: rdata_d = {8'h00, addr_q};
            REG_DATA: rdata_d = data_q;
            default:  rdata_d = '0;
         endcase
      end

      // Register writes are rejected while a sequence runs.
      if (wb.cyc && wb.stb && wb.we) begin
         if (busy_q) begin
            err_d = 1'b1;
         end else begin
            case (wb.addr)
               REG_CTRL: if (wb.wdata[1:0] == CMD_PROG || wb.wdata[1:0] == CMD_ERASE) begin
                  prog_d  = (wb.wdata[1:0] == CMD_PROG);
                  err_d   = 1'b0;
                  busy_d  = 1'b1;
                  state_d = S_REL0;
                  cnt_d   = 2'd0;
                  pend_d  = 1'b0;
               end
               REG_ADDR: addr_d = wb.wdata[23:0];
               REG_DATA: data_d = wb.wdata;
               default: ;
            endcase
         end
      end

      // Each state issues one transfer, then advances on its completion.
      if (state_q != S_IDLE) begin
         if (!pend_q) begin
            start_d   = 1'b1;
            pend_d    = 1'b1;
            cs_n_d    = 1'b0;
            tx_byte_d = 8'h00;
            case (state_q)
               S_REL0, S_WREL, S_OREL, S_SREL: cs_n_d = 1'b1;
               S_WEN:  tx_byte_d = OPC_WREN;
               S_OP:   tx_byte_d = prog_q ? OPC_PP : OPC_SE;
               S_ADR: case (cnt_q)
                  2'd0:    tx_byte_d = seq_addr[23:16];
                  2'd1:    tx_byte_d = seq_addr[15:8];
                  default: tx_byte_d = seq_addr[7:0];
               endcase
               S_DAT: case (cnt_q)
                  2'd0:    tx_byte_d = data_q[31:24];
                  2'd1:    tx_byte_d = data_q[23:16];
                  2'd2:    tx_byte_d = data_q[15:8];
                  default: tx_byte_d = data_q[7:0];
               endcase
               S_RDSR: tx_byte_d = OPC_RDSR;
               default: ;
            endcase
         end else if (xfer_done) begin
            pend_d = 1'b0;
            case (state_q)
               S_REL0: state_d = S_WEN;
               S_WEN:  state_d = S_WREL;
               S_WREL: state_d = S_OP;
               S_OP: begin
                  state_d = S_ADR;
                  cnt_d   = 2'd0;
               end
               S_ADR: if (cnt_q == 2'd2) begin
                  cnt_d   = 2'd0;
                  state_d = prog_q ? S_DAT : S_OREL;
               end else begin
                  cnt_d = cnt_q + 2'd1;
               end
               S_DAT: if (cnt_q == 2'd3) begin
                  cnt_d   = 2'd0;
                  state_d = S_OREL;
               end else begin
                  cnt_d = cnt_q + 2'd1;
               end
               S_OREL: begin
                  state_d = S_RDSR;
`ifdef SPIFLASH_POLL_TIMEOUT_EN
                  poll_d  = '0;
`endif
               end
               S_RDSR: state_d = S_STAT;
               S_STAT: if (xfer_rx[0]) begin
`ifdef SPIFLASH_POLL_TIMEOUT_EN
                  if (poll_q == POLL_LAST) begin
                     err_d   = 1'b1;
                     state_d = S_SREL;
                  end else begin
                     poll_d = poll_q + LGPOLL'(1);
                  end
`endif
               end else begin
                  state_d = S_SREL;
               end
               S_SREL: begin
                  state_d = S_IDLE;
                  busy_d  = 1'b0;
               end
               default: state_d = S_IDLE;
            endcase
         end
      end
   end

   flctl_byte_xfer u_xfer (
      .clk_i      (i_clk),
      .rst_n_i    (i_reset_n),
      .start_i    (start_q),
      .cs_n_i     (cs_n_q),
      .byte_i     (tx_byte_q),
      .fl_stall_i (fl.stall),
      .fl_ack_i   (fl.ack),
      .fl_rdata_i (fl.rdata),
      .fl_cyc_o   (fl.cyc),
      .fl_stb_o   (fl.stb),
      .fl_data_o  (fl.wdata),
      .done_c_o   (xfer_done),
      .rxbyte_c_o (xfer_rx)
   );

   assign fl.we    = 1'b1;
   assign fl.addr  = FL_CTRL_ADDR;
   assign wb.stall = 1'b0;
   assign wb.ack   = ack_q;
   assign wb.rdata = rdata_q;

endmodule
